buffer_arbiter: RTL and testbench

- Controls the shared endpoint data buffer, an external single-port SRAM with 1-cycle read latency.
- Two requesters share it: the host-bus side (AHB slave) and the USB side (protocol RX/TX path).
- The block arbitrates one access per cycle, keeps the FIFO pointers and the occupancy count, and enforces buffer ownership so data flows one direction at a time.
- Its outputs buffer_occupancy and buffer_reserved feed the protocol controller.

---
 rtl/buffer_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_buffer_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_arbiter.sv
// buffer_arbiter: arbitrates host-bus and USB access to the shared endpoint data buffer
// (external single-port SRAM, 1-cycle read latency). It keeps the FIFO pointers and the
// occupancy count, and locks buffer ownership so data flows one direction at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   host_store_req/get_req   host level requests, held until host_ack
//   host_wdata/host_rdata    host write byte / read byte (valid with host_ack)
//   host_ack/host_err        one-cycle completion pulse / rejected-request flag
//   usb_*                    same set for the USB (protocol RX/TX) side
//   clear                    synchronous flush of pointers, occupancy and ownership
//   mem_en/we/addr/wdata     SRAM access, driven in the grant cycle
//   mem_rdata                SRAM read data, one cycle after the read access
//   buffer_occupancy         bytes stored, 0..DEPTH
//   buffer_reserved          occupancy != 0 (ownership locked)
//   data_dir                 writer side: 0 host->USB, 1 USB->host
//   empty/full               occupancy == 0 / occupancy == DEPTH
module buffer_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_store_req,
    input  logic              host_get_req,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              host_err,
    input  logic              usb_store_req,
    input  logic              usb_get_req,
    input  logic [DATA_W-1:0] usb_wdata,
    output logic [DATA_W-1:0] usb_rdata,
    output logic              usb_ack,
    output logic              usb_err,
    input  logic              clear,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   buffer_occupancy,
    output logic              buffer_reserved,
    output logic              data_dir,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    // Side encoding matches data_dir: 0 = host, 1 = USB.
    localparam logic SIDE_HOST = 1'b0;
    localparam logic SIDE_USB  = 1'b1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              data_dir_q, data_dir_d;
    logic              last_grant_q, last_grant_d;
    logic              host_pend_q, host_pend_d;
    logic              usb_pend_q, usb_pend_d;
    logic              host_err_q, host_err_d;
    logic              usb_err_q, usb_err_d;
    logic              host_getv_q, host_getv_d;
    logic              usb_getv_q, usb_getv_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] usb_rdata_q, usb_rdata_d;

    logic host_elig, usb_elig;
    logic grant_host, grant_usb, any_grant;
    logic side, is_store, store_ok, get_ok, access_ok;
    logic is_empty, is_full;

    always_comb begin
        is_empty = (occ_q == '0);
        is_full  = (occ_q == FULL_CNT);

        // rst gates grants so the SRAM interface stays idle while reset is held.
        host_elig = (host_store_req | host_get_req) & ~host_pend_q & ~clear & ~rst;
        usb_elig  = (usb_store_req | usb_get_req) & ~usb_pend_q & ~clear & ~rst;

        // Round-robin on a tie: the side that did not win last time goes first.
        grant_host = host_elig & (~usb_elig | (last_grant_q == SIDE_USB));
        grant_usb  = usb_elig & (~host_elig | (last_grant_q == SIDE_HOST));
        any_grant  = grant_host | grant_usb;
        side       = grant_usb;

        // Store takes precedence when a side raises both requests.
        is_store  = grant_usb ? usb_store_req : host_store_req;
        store_ok  = is_empty | ((data_dir_q == side) & ~is_full);
        get_ok    = ~is_empty & (data_dir_q != side);
        access_ok = any_grant & (is_store ? store_ok : get_ok);

        mem_en    = access_ok;
        mem_we    = access_ok & is_store;
        mem_addr  = '0;
        mem_wdata = '0;
        if (access_ok) begin
            mem_addr = is_store ? wr_ptr_q : rd_ptr_q;
            if (is_store) begin
                mem_wdata = grant_usb ? usb_wdata : host_wdata;
            end
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        data_dir_d   = data_dir_q;
        last_grant_d = any_grant ? side : last_grant_q;

        host_pend_d = grant_host;
        usb_pend_d  = grant_usb;
        host_err_d  = grant_host & ~access_ok;
        usb_err_d   = grant_usb & ~access_ok;
        host_getv_d = grant_host & access_ok & ~is_store;
        usb_getv_d  = grant_usb & access_ok & ~is_store;

        // Read data lands the cycle after the grant; a clear in that cycle discards it.
        host_rdata_d = (host_getv_q & ~clear) ? mem_rdata : host_rdata_q;
        usb_rdata_d  = (usb_getv_q & ~clear) ? mem_rdata : usb_rdata_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            data_dir_d = 1'b0;
        end else if (access_ok) begin
            if (is_store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                occ_d    = occ_q + 1'b1;
                if (is_empty) begin
                    data_dir_d = side;
                end
            end else if (occ_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                // Last byte drained: restart the next packet at address 0.
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                occ_d      = '0;
                data_dir_d = 1'b0;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                occ_d    = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            data_dir_q   <= 1'b0;
            last_grant_q <= SIDE_HOST;
            host_pend_q  <= 1'b0;
            usb_pend_q   <= 1'b0;
            host_err_q   <= 1'b0;
            usb_err_q    <= 1'b0;
            host_getv_q  <= 1'b0;
            usb_getv_q   <= 1'b0;
            host_rdata_q <= '0;
            usb_rdata_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            data_dir_q   <= data_dir_d;
            last_grant_q <= last_grant_d;
            host_pend_q  <= host_pend_d;
            usb_pend_q   <= usb_pend_d;
            host_err_q   <= host_err_d;
            usb_err_q    <= usb_err_d;
            host_getv_q  <= host_getv_d;
            usb_getv_q   <= usb_getv_d;
            host_rdata_q <= host_rdata_d;
            usb_rdata_q  <= usb_rdata_d;
        end
    end

    always_comb begin
        host_ack         = host_pend_q;
        host_err         = host_err_q;
        usb_ack          = usb_pend_q;
        usb_err          = usb_err_q;
        // Pass SRAM data straight through in the ack cycle, then hold it.
        host_rdata       = (host_getv_q & ~clear) ? mem_rdata : host_rdata_q;
        usb_rdata        = (usb_getv_q & ~clear) ? mem_rdata : usb_rdata_q;
        buffer_occupancy = occ_q;
        buffer_reserved  = ~is_empty;
        data_dir         = data_dir_q;
        empty            = is_empty;
        full             = is_full;
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
module tb_buffer_arbiter;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    logic host_store_req, host_get_req, usb_store_req, usb_get_req, clear;
    logic [7:0] host_wdata, usb_wdata, host_rdata, usb_rdata;
    logic host_ack, host_err, usb_ack, usb_err;
    logic mem_en, mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [6:0] buffer_occupancy;
    logic buffer_reserved, data_dir, empty, full;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: buffer contents as a FIFO of bytes plus ownership.
    logic [7:0] byte_q[$];
    int   rd_base, owner, last;
    bit   pend[2], perr[2], pget[2];
    logic [7:0] pdata[2], hold[2];

    logic [7:0] sram[DEPTH];

    buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .host_store_req(host_store_req), .host_get_req(host_get_req),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .host_err(host_err),
        .usb_store_req(usb_store_req), .usb_get_req(usb_get_req),
        .usb_wdata(usb_wdata), .usb_rdata(usb_rdata),
        .usb_ack(usb_ack), .usb_err(usb_err),
        .clear(clear),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .buffer_occupancy(buffer_occupancy), .buffer_reserved(buffer_reserved),
        .data_dir(data_dir), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Single-port SRAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        byte_q.delete();
        rd_base = 0; owner = 0; last = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; perr[i] = 0; pget[i] = 0; pdata[i] = 8'h0; hold[i] = 8'h0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_host_ack"}, host_ack, 0);
        check_eq({tag, "_host_err"}, host_err, 0);
        check_eq({tag, "_usb_ack"}, usb_ack, 0);
        check_eq({tag, "_usb_err"}, usb_err, 0);
        check_eq({tag, "_host_rdata"}, host_rdata, 0);
        check_eq({tag, "_usb_rdata"}, usb_rdata, 0);
        check_eq({tag, "_mem_en"}, mem_en, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_occupancy"}, buffer_occupancy, 0);
        check_eq({tag, "_reserved"}, buffer_reserved, 0);
        check_eq({tag, "_data_dir"}, data_dir, 0);
        check_eq({tag, "_empty"}, empty, 1);
        check_eq({tag, "_full"}, full, 0);
    endtask

    // Assert reset with random request inputs; called just after a rising edge.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        host_store_req = 1'($urandom); host_get_req = 1'($urandom);
        usb_store_req  = 1'($urandom); usb_get_req  = 1'($urandom);
        host_wdata = 8'($urandom); usb_wdata = 8'($urandom);
        clear = 1'($urandom);
        #2;
        check_idle_outputs("rst");
        repeat (cycles) @(posedge clk);
        #1;
        check_idle_outputs("rst_hold");
        rst = 1'b0;
        clear = 1'b0;
        model_reset();
    endtask

    // Apply one cycle of inputs, compare everything against the model, then clock.
    task automatic step(input bit hs, input bit hg, input bit us, input bit ug,
                        input logic [7:0] hw, input logic [7:0] uw, input bit clr);
        int occ, g, addr;
        bit emp, ful, eh, eu, st, ok;
        logic [7:0] wd;
        bit npend[2], nperr[2], npget[2];
        host_store_req = hs; host_get_req = hg; usb_store_req = us; usb_get_req = ug;
        host_wdata = hw; usb_wdata = uw; clear = clr;
        #2;
        occ = byte_q.size();
        emp = (occ == 0);
        ful = (occ == DEPTH);
        check_eq("occupancy", buffer_occupancy, occ);
        check_eq("empty", empty, emp);
        check_eq("full", full, ful);
        check_eq("reserved", buffer_reserved, !emp);
        check_eq("data_dir", data_dir, owner);
        check_eq("host_ack", host_ack, pend[0]);
        check_eq("host_err", host_err, perr[0]);
        check_eq("usb_ack", usb_ack, pend[1]);
        check_eq("usb_err", usb_err, perr[1]);
        for (int s = 0; s < 2; s++) if (pend[s] && pget[s] && !clr) hold[s] = pdata[s];
        check_eq("host_rdata", host_rdata, hold[0]);
        check_eq("usb_rdata", usb_rdata, hold[1]);

        eh = (hs || hg) && !pend[0] && !clr;
        eu = (us || ug) && !pend[1] && !clr;
        g = -1;
        if (eh && eu) g = (last == 0) ? 1 : 0;
        else if (eh)  g = 0;
        else if (eu)  g = 1;
        ok = 0; st = 0; addr = 0; wd = 8'h0;
        if (g >= 0) begin
            st = (g == 0) ? hs : us;
            wd = (g == 0) ? hw : uw;
            if (st) begin
                ok = emp || (owner == g && !ful);
                addr = (rd_base + occ) % DEPTH;
            end else begin
                ok = !emp && owner != g;
                addr = rd_base;
            end
        end
        check_eq("mem_en", mem_en, ok);
        check_eq("mem_we", mem_we, ok && st);
        if (ok) begin
            check_eq("mem_addr", mem_addr, addr);
            if (st) check_eq("mem_wdata", mem_wdata, wd);
        end

        npend = '{0, 0}; nperr = '{0, 0}; npget = '{0, 0};
        if (g >= 0) begin
            npend[g] = 1; nperr[g] = !ok; npget[g] = ok && !st;
            last = g;
        end
        if (clr) begin
            byte_q.delete(); rd_base = 0; owner = 0;
        end else if (ok) begin
            if (st) begin
                if (emp) owner = g;
                byte_q.push_back(wd);
            end else begin
                pdata[g] = byte_q.pop_front();
                rd_base = (rd_base + 1) % DEPTH;
                if (byte_q.size() == 0) begin
                    rd_base = 0; owner = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        pend = npend; perr = nperr; pget = npget;
    endtask

    initial begin
        logic [7:0] t2 [3];
        bit rhs, rhg, rus, rug;
        logic [7:0] rhw, ruw;
        int mode, r;
        t2[0] = 8'hA1; t2[1] = 8'hB2; t2[2] = 8'hC3;
        model_reset();
        do_reset(2);

        // Idle after reset: no SRAM activity.
        repeat (3) step(0, 0, 0, 0, 8'h0, 8'h0, 0);

        // Host fills three bytes, USB drains them, next packet restarts at 0.
        for (int i = 0; i < 3; i++) repeat (2) step(1, 0, 0, 0, t2[i], 8'h0, 0);
        repeat (6) step(0, 0, 0, 1, 8'h0, 8'h0, 0);
        repeat (2) step(1, 0, 0, 0, 8'h5A, 8'h0, 0);
        repeat (2) step(0, 0, 0, 1, 8'h0, 8'h0, 0);

        // Simultaneous stores on an empty buffer after reset: USB wins, host rejected.
        do_reset(1);
        repeat (3) step(1, 0, 1, 0, 8'h11, 8'h22, 0);
        step(0, 0, 0, 0, 8'h0, 8'h0, 0);
        repeat (4) step(0, 1, 0, 0, 8'h0, 8'h0, 0);

        // USB fills to 64, then one more store is rejected; host drains, then gets on empty.
        for (int i = 0; i < 130; i++) step(0, 0, 1, 0, 8'h0, 8'(i * 7 + 3), 0);
        repeat (128) step(0, 1, 0, 0, 8'h0, 8'h0, 0);
        repeat (2) step(0, 1, 0, 0, 8'h0, 8'h0, 0);

        // Host-owned buffer of 4 bytes, host store and USB get interleave each cycle.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'(i + 8'h40), 8'h0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 8'(i + 8'h60), 8'h0, 0);
        repeat (14) step(0, 0, 0, 1, 8'h0, 8'h0, 0);

        // clear in the ack cycle of a host store; USB then starts a new packet at 0.
        step(1, 0, 0, 0, 8'h77, 8'h0, 0);
        step(1, 0, 0, 0, 8'h77, 8'h0, 1);
        repeat (2) step(0, 0, 1, 0, 8'h0, 8'h88, 0);
        step(0, 0, 0, 0, 8'h0, 8'h0, 1);

        // Async reset right after a grant: the pending ack is dropped.
        step(0, 0, 1, 0, 8'h0, 8'h99, 0);
        do_reset(1);

        // Randomized traffic with biased phases so the buffer fills and drains.
        rhs = 0; rhg = 0; rus = 0; rug = 0; rhw = 8'h0; ruw = 8'h0; mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) mode = int'($urandom_range(0, 2));
            if (pend[0] || !(rhs || rhg)) begin
                r = int'($urandom_range(0, 9));
                rhs = (mode == 0) ? (r < 6) : (mode == 1) ? (r == 0) : (r < 4);
                rhg = (mode == 0) ? (r == 6) : (mode == 1) ? (r >= 4) : (r >= 4 && r < 7);
                rhw = 8'($urandom);
            end
            if (pend[1] || !(rus || rug)) begin
                r = int'($urandom_range(0, 9));
                rus = (mode == 1) ? (r < 6) : (mode == 0) ? (r == 0) : (r < 4);
                rug = (mode == 1) ? (r == 6) : (mode == 0) ? (r >= 4) : (r >= 4 && r < 7);
                ruw = 8'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1);
                rhs = 0; rhg = 0; rus = 0; rug = 0;
            end else begin
                step(rhs, rhg, rus, rug, rhw, ruw, $urandom_range(0, 149) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
